half_duplex_parity_link: RTL and testbench
==========================================

HALF_DUPLEX_PARITY_LINK -- requirements
Module: half_duplex_parity_link

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload bits per frame, legal range 5..16.
REQ-002 SHALL have parameter BIT_CYC, default 4, meaning clk cycles per serial bit, even, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port dir, input, 1 bit: 0 = transmit, 1 = receive.
REQ-006 SHALL have port tx_mode, input, 2 bits: 00 no parity, 01 even, 10 odd, 11 reserved (behaves as 00).
REQ-007 SHALL have port start, input, 1 bit: transmit request, sampled in IDLE only.
REQ-008 SHALL have port stop, input, 1 bit: abort current frame.
REQ-009 SHALL have port din, input, DATA_W bits: transmit payload, captured on accepted start.
REQ-010 SHALL have port line_in, input, 1 bit: serial receive line, synchronous to clk, idle high.
REQ-011 SHALL have port line_out, output, 1 bit: serial transmit line, idle high.
REQ-012 SHALL have port line_oe, output, 1 bit: drive enable, high only while transmitting.
REQ-013 SHALL have port dout, output, DATA_W bits: last received payload.
REQ-014 SHALL have port done, output, 1 bit: one-cycle frame-complete pulse (TX or RX).
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-016 SHALL have ports par_err and frame_err, outputs, 1 bit each: receive error flags.

Function
REQ-017 SHALL frame as: start bit 0, DATA_W data bits LSB first, parity bit if P=1 (P = 1 for modes 01/10, else 0), stop bit 1; each bit lasts BIT_CYC cycles.
REQ-018 SHALL use one shared FSM: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when P=0.
REQ-019 SHALL latch dir and tx_mode on frame start; changes mid-frame are ignored.
REQ-020 TX: start=1 in IDLE with dir=0 SHALL latch din, enter START next cycle, drive line_out=0 and line_oe=1 from that cycle.
REQ-021 TX SHALL last exactly BIT_CYC*(DATA_W+2+P) cycles; done SHALL pulse in the cycle after the last STOP cycle, concurrent with return to IDLE, with line_oe=0.
REQ-022 Parity bit SHALL be XOR of payload for even mode and its inverse for odd mode.
REQ-023 RX: in IDLE with dir=1, line_in=0 SHALL enter START; every bit SHALL be sampled when its in-bit counter reaches BIT_CYC/2.
REQ-024 RX start bit sampled as 1 SHALL return to IDLE silently: no done, no flag change.
REQ-025 RX SHALL load dout, par_err (parity mismatch) and frame_err (stop bit sampled 0) at the stop-bit sample point and pulse done one cycle later.
REQ-026 par_err and frame_err SHALL hold until the next frame enters START, then clear.
REQ-027 start while busy SHALL be ignored; start with dir=1 SHALL be ignored.
REQ-028 stop=1 in any non-IDLE state SHALL force IDLE next cycle: line_out=1, line_oe=0, no done, dout unchanged; stop in IDLE has no effect.
REQ-029 stop and start asserted together in IDLE SHALL not start a frame (stop wins).

Reset
REQ-030 rst=0 SHALL immediately force IDLE, line_out=1, line_oe=0, dout=0, done=0, busy=0, par_err=0, frame_err=0, counters=0, including mid-frame.
REQ-031 The first frame after rst deasserts SHALL be accepted on the first clock edge with start=1.

Verification
REQ-032 TX, DATA_W=8, BIT_CYC=4, tx_mode=01, din=8'h81 -> line_out bits 0,1,0,0,0,0,0,0,1,0,1, each held 4 cycles; done pulses 44 cycles after START entry.
REQ-033 RX, tx_mode=10, line_in carries 8'h83 with parity bit 0 and stop 1 -> dout=8'h83, par_err=0, frame_err=0, one done pulse.
REQ-034 RX of 8'h83 with tx_mode=01 and parity bit 0 -> par_err=1 and dout=8'h83; stop bit driven 0 -> frame_err=1.
REQ-035 stop=1 during DATA of a TX frame -> IDLE next cycle, line_out=1, line_oe=0, no done; next start is accepted normally.
REQ-036 rst=0 mid-RX frame -> all outputs at reset values immediately; start pulse during busy and a 1-cycle low glitch on line_in -> no frame, no done.

Source files
------------

// File: rtl/half_duplex_parity_link.sv
// Half-duplex serial link: one shared frame FSM either drives a parity-protected
// frame onto line_out or samples one from line_in, selected by dir at frame start.
module half_duplex_parity_link #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BIT_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dir,
  input  logic [1:0]        tx_mode,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] din,
  input  logic              line_in,
  output logic              line_out,
  output logic              line_oe,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy,
  output logic              par_err,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(BIT_CYC + 2);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned HALF  = BIT_CYC / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              rxd, rxd_n;
  logic              pen, pen_n;
  logic              odd, odd_n;
  logic              rx_bad, rx_bad_n;
  logic [DATA_W-1:0] dout_n;
  logic              pe_n, fe_n, done_n, busy_n;
  logic              line_out_n, line_oe_n, tx_act;
  logic              bit_end, sample;

  assign bit_end = (cnt == CNT_W'(BIT_CYC - 1));
  assign sample  = (cnt == CNT_W'(HALF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rxd       <= 1'b0;
      pen       <= 1'b0;
      odd       <= 1'b0;
      rx_bad    <= 1'b0;
      dout      <= '0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      line_out  <= 1'b1;
      line_oe   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      rxd       <= rxd_n;
      pen       <= pen_n;
      odd       <= odd_n;
      rx_bad    <= rx_bad_n;
      dout      <= dout_n;
      par_err   <= pe_n;
      frame_err <= fe_n;
      done      <= done_n;
      busy      <= busy_n;
      line_out  <= line_out_n;
      line_oe   <= line_oe_n;
    end
  end

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    rxd_n    = rxd;
    pen_n    = pen;
    odd_n    = odd;
    rx_bad_n = rx_bad;
    dout_n   = dout;
    pe_n     = par_err;
    fe_n     = frame_err;
    done_n   = 1'b0;

    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        pen_n = (tx_mode == 2'b01) || (tx_mode == 2'b10);
        odd_n = (tx_mode == 2'b10);
        if (!dir && start && !stop) begin
          state_n = START;
          rxd_n   = 1'b0;
          shreg_n = din;
          pe_n    = 1'b0;
          fe_n    = 1'b0;
        end else if (dir && !line_in) begin
          state_n = START;
          rxd_n   = 1'b1;
        end
      end
      START: begin
        if (rxd && sample && line_in) begin
          state_n = IDLE;
        end else begin
          // Flags clear only once a receive start bit is confirmed.
          if (rxd && sample) begin
            pe_n = 1'b0;
            fe_n = 1'b0;
          end
          if (bit_end) state_n = DATA;
        end
      end
      DATA: begin
        if (rxd && sample) shreg_n[idx] = line_in;
        if (bit_end) begin
          if (idx == IDX_W'(DATA_W - 1)) state_n = pen ? PARITY : STOP;
          else idx_n = idx + IDX_W'(1);
        end
      end
      PARITY: begin
        if (rxd && sample) rx_bad_n = line_in ^ odd ^ (^shreg);
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (rxd) begin
          // Receive ends one cycle after the stop sample, not at the bit end.
          cnt_n = cnt + CNT_W'(1);
          if (sample) begin
            dout_n = shreg;
            pe_n   = pen & rx_bad;
            fe_n   = ~line_in;
          end
          if (cnt == CNT_W'(HALF + 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else if (bit_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort leaves received data and flags untouched.
    if (state != IDLE && stop) begin
      state_n = IDLE;
      done_n  = 1'b0;
      cnt_n   = '0;
      idx_n   = '0;
      dout_n  = dout;
      pe_n    = par_err;
      fe_n    = frame_err;
    end

    busy_n     = (state_n != IDLE);
    tx_act     = busy_n && !rxd_n;
    line_oe_n  = tx_act;
    line_out_n = 1'b1;
    if (tx_act) begin
      case (state_n)
        START:   line_out_n = 1'b0;
        DATA:    line_out_n = shreg_n[idx_n];
        PARITY:  line_out_n = odd_n ^ (^shreg_n);
        default: line_out_n = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_half_duplex_parity_link.sv
// Randomized bench for half_duplex_parity_link: per-cycle expected waveforms are
// built from frame-level rules and compared against the DUT on every falling edge.
module tb_half_duplex_parity_link;
  localparam int unsigned DW   = 8;
  localparam int unsigned B    = 4;
  localparam int unsigned HALF = B / 2;
  localparam int NCYC = 6000;

  logic clk = 1'b0, rst = 1'b0, dir = 1'b0, start = 1'b0, stop = 1'b0, line_in = 1'b1;
  logic [1:0]    tx_mode = 2'b00;
  logic [DW-1:0] din = '0;
  logic line_out, line_oe, done, busy, par_err, frame_err;
  logic [DW-1:0] dout;

  half_duplex_parity_link #(.DATA_W(DW), .BIT_CYC(B)) dut (
    .clk(clk), .rst(rst), .dir(dir), .tx_mode(tx_mode), .start(start), .stop(stop),
    .din(din), .line_in(line_in), .line_out(line_out), .line_oe(line_oe), .dout(dout),
    .done(done), .busy(busy), .par_err(par_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          e_lo [NCYC];
  logic          e_oe [NCYC];
  logic          e_busy [NCYC];
  logic          e_done [NCYC];
  logic          e_pe [NCYC];
  logic          e_fe [NCYC];
  logic [DW-1:0] e_dout [NCYC];

  int checks = 0, errors = 0, done_cnt = 0;
  logic [10:0] pin_seq = 11'b10100000010;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < NCYC) begin
      chk("line_out", 32'(line_out), 32'(e_lo[cyc]));
      chk("line_oe", 32'(line_oe), 32'(e_oe[cyc]));
      chk("busy", 32'(busy), 32'(e_busy[cyc]));
      chk("done", 32'(done), 32'(e_done[cyc]));
      chk("dout", 32'(dout), 32'(e_dout[cyc]));
      chk("par_err", 32'(par_err), 32'(e_pe[cyc]));
      chk("frame_err", 32'(frame_err), 32'(e_fe[cyc]));
    end
    if (done === 1'b1) done_cnt++;
  end

  function automatic bit par_on(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  function automatic logic par_bit(input logic [DW-1:0] d, input logic [1:0] m);
    return (m == 2'b10) ? ~^d : ^d;
  endfunction

  task automatic fill_idle(input int from);
    for (int t = from; t < NCYC; t++) begin
      e_lo[t] = 1'b1; e_oe[t] = 1'b0; e_busy[t] = 1'b0; e_done[t] = 1'b0;
    end
  endtask

  task automatic fill_dout(input int from, input logic [DW-1:0] v);
    for (int t = from; t < NCYC; t++) e_dout[t] = v;
  endtask

  task automatic fill_flags(input int from, input logic pe, input logic fe);
    for (int t = from; t < NCYC; t++) begin
      e_pe[t] = pe; e_fe[t] = fe;
    end
  endtask

  task automatic set_at(input int t, input logic lo, input logic oe, input logic bz);
    if (t < NCYC) begin
      e_lo[t] = lo; e_oe[t] = oe; e_busy[t] = bz;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmit one frame; abort_at>0 raises stop that many cycles after the start request.
  task automatic tx_frame(input logic [DW-1:0] d, input logic [1:0] m, input int abort_at,
                          input bit pin);
    logic bits[$];
    int n, nb, len, limit;
    n = cyc;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(d[i]);
    if (par_on(m)) bits.push_back(par_bit(d, m));
    bits.push_back(1'b1);
    nb  = bits.size();
    len = nb * int'(B);
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < int'(B); j++) set_at(n + 1 + i * int'(B) + j, bits[i], 1'b1, 1'b1);
    if (n + 1 + len < NCYC) e_done[n + 1 + len] = 1'b1;
    fill_flags(n + 1, 1'b0, 1'b0);
    if (abort_at > 0) fill_idle(n + abort_at + 1);
    limit = (abort_at > 0) ? abort_at : len;
    dir = 1'b0; tx_mode = m; din = d; start = 1'b1; stop = 1'b0;
    for (int t = 1; t <= len + 2; t++) begin
      tick();
      if (pin) begin
        if (t >= 2 && t <= 42 && ((t - 2) % 4) == 0)
          chk("tx81_bit", 32'(line_out), 32'(pin_seq[(t - 2) / 4]));
        if (t == len) chk("tx81_done_early", 32'(done), 32'd0);
        if (t == len + 1) chk("tx81_done_at_44", 32'(done), 32'd1);
      end
      if (t < limit) begin
        start   = 1'($urandom);
        dir     = 1'($urandom);
        tx_mode = 2'($urandom);
        din     = DW'($urandom);
      end else begin
        start = 1'b0;
        dir   = 1'b0;
      end
      stop = (t == abort_at);
    end
    stop = 1'b0;
  endtask

  // Receive one frame; rst_at>0 asserts reset that many cycles into it.
  task automatic rx_frame(input logic [DW-1:0] d, input logic [1:0] m, input bit flip,
                          input logic stopb, input int rst_at);
    logic bits[$];
    int s, nb, c, o;
    s = cyc;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(d[i]);
    if (par_on(m)) bits.push_back(par_bit(d, m) ^ flip);
    bits.push_back(stopb);
    nb = bits.size();
    c  = s + 1 + (nb - 1) * int'(B) + int'(HALF);
    for (int t = s + 1; t <= c + 1; t++) set_at(t, 1'b1, 1'b0, 1'b1);
    fill_flags(s + 2 + int'(HALF), 1'b0, 1'b0);
    fill_dout(c + 1, d);
    fill_flags(c + 1, par_on(m) && flip, ~stopb);
    if (c + 2 < NCYC) e_done[c + 2] = 1'b1;
    if (rst_at > 0) begin
      fill_idle(s + rst_at);
      fill_dout(s + rst_at, '0);
      fill_flags(s + rst_at, 1'b0, 1'b0);
    end
    dir = 1'b1; tx_mode = m;
    o = 0;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < int'(B); j++) begin
        if (rst_at > 0 && o >= rst_at) begin
          rst = 1'b0;
          line_in = 1'b1;
        end else begin
          line_in = bits[i];
        end
        if (o >= 1) begin
          tx_mode = 2'($urandom);
          start   = 1'($urandom);
          dir     = 1'($urandom);
        end
        tick();
        o++;
      end
    end
    line_in = 1'b1; start = 1'b0; dir = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // Single-cycle low glitch on the receive line, with a start request while busy.
  task automatic rx_glitch();
    int s;
    s = cyc;
    for (int t = s + 1; t <= s + 1 + int'(HALF); t++) set_at(t, 1'b1, 1'b0, 1'b1);
    dir = 1'b1; line_in = 1'b0;
    tick();
    line_in = 1'b1; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; dir = 1'b1;
    repeat (HALF + 3) tick();
  endtask

  initial begin
    int d0, kind, len, ab;
    logic [1:0] m;
    for (int t = 0; t < NCYC; t++) begin
      e_lo[t] = 1'b1; e_oe[t] = 1'b0; e_busy[t] = 1'b0; e_done[t] = 1'b0;
      e_pe[t] = 1'b0; e_fe[t] = 1'b0; e_dout[t] = '0;
    end
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_line_out", 32'(line_out), 32'd1);
    chk("reset_dout", 32'(dout), 32'd0);
    rst = 1'b1;

    tx_frame(8'h81, 2'b01, 0, 1'b1);

    d0 = done_cnt;
    rx_frame(8'h83, 2'b10, 1'b0, 1'b1, 0);
    chk("rx83_dout", 32'(dout), 32'h83);
    chk("rx83_par_err", 32'(par_err), 32'd0);
    chk("rx83_frame_err", 32'(frame_err), 32'd0);
    chk("rx83_done_pulses", 32'(done_cnt - d0), 32'd1);

    rx_frame(8'h83, 2'b01, 1'b1, 1'b1, 0);
    chk("rx83_even_par_err", 32'(par_err), 32'd1);
    chk("rx83_even_dout", 32'(dout), 32'h83);
    rx_frame(8'h83, 2'b01, 1'b0, 1'b0, 0);
    chk("rx83_stop0_frame_err", 32'(frame_err), 32'd1);

    d0 = done_cnt;
    rx_glitch();
    chk("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    chk("glitch_flags_held", 32'(frame_err), 32'd1);

    d0 = done_cnt;
    tx_frame(8'h5A, 2'b00, 2 * int'(B) + 3, 1'b0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    tx_frame(8'hC3, 2'b10, 0, 1'b0);

    dir = 1'b0; din = 8'hFF; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b0;
    tick();
    chk("start_stop_idle", 32'(busy), 32'd0);

    rx_frame(DW'($urandom), 2'b01, 1'b0, 1'b1, 15);
    tx_frame(DW'($urandom), 2'b11, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      kind = int'($urandom_range(0, 3));
      m    = 2'($urandom);
      if (kind <= 1) begin
        len = (int'(DW) + 2 + (par_on(m) ? 1 : 0)) * int'(B);
        ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
        tx_frame(DW'($urandom), m, ab, 1'b0);
      end else if (kind == 2) begin
        rx_frame(DW'($urandom), m, 1'($urandom), 1'($urandom), 0);
      end else begin
        rx_glitch();
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
